sram_rw_ctrl: RTL
=================

SRAM_RW_CTRL -- requirements
Module: sram_rw_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 8: number of word rows (one-hot row lines).
REQ-002 SHALL have parameter WIDTH, default 4: number of columns (bits per word).
REQ-003 SHALL have parameter WR_CYC, default 2: cycles row_wr is held high per write (>=1).
REQ-004 SHALL have parameter RD_CYC, default 2: cycles row_rd is held high before the sense cycle (>=1).
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  controller can accept a request.
REQ-010 req_we  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  AW=$clog2(ROWS) (min 1)  row address.
REQ-012 req_wdata  input  WIDTH  write data.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  response consumer ready.
REQ-015 rsp_rdata  output  WIDTH  read data (0 for writes and errors).
REQ-016 rsp_err  output  1  request address out of range.
REQ-017 row_wr  output  ROWS  one-hot write word lines to cells.
REQ-018 row_rd  output  ROWS  one-hot read word lines to cells.
REQ-019 bl_wr / blb_wr  output  real[WIDTH]  write bitline pair voltages.
REQ-020 bl_rd / blb_rd  input  real[WIDTH]  read bitline voltages from cells; blb_rd is monitored only and not used for the data decision.

Function
REQ-021 SHALL implement the FSM IDLE -> WR_SETUP -> WR_PULSE -> WR_HOLD -> RESP for writes, and IDLE -> RD_ACCESS -> RD_SENSE -> RESP for reads.
REQ-022 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid && req_ready.
REQ-023 On acceptance, SHALL register we, addr and wdata; inputs are don't-care afterwards.
REQ-024 Out of range (addr >= ROWS) SHALL go directly to RESP with rsp_err=1 and rsp_rdata=0; no row line ever asserts.
REQ-025 WR_SETUP (1 cycle): bl_wr[i] = wdata[i] ? VDD : VSS, blb_wr[i] = complement; all row lines low.
REQ-026 WR_PULSE (WR_CYC cycles): row_wr[addr]=1 with bitlines held.
REQ-027 WR_HOLD (1 cycle): row_wr low with bitlines still held; then RESP.
REQ-028 Outside WR_SETUP, WR_PULSE and WR_HOLD, bl_wr and blb_wr SHALL be VSS.
REQ-029 RD_ACCESS (RD_CYC cycles) and RD_SENSE (1 cycle) SHALL drive row_rd[addr]=1.
REQ-030 At the end of RD_SENSE, SHALL register rdata[i] = (bl_rd[i] >= VTH).
REQ-031 row_rd SHALL be low in RESP.
REQ-032 In RESP, rsp_valid=1 with stable rsp_rdata and rsp_err; the FSM returns to IDLE on rsp_valid && rsp_ready.
REQ-033 Default latency from the accept edge to rsp_valid: write 1+WR_CYC+1 = 4 cycles; read RD_CYC+1 = 3 cycles; error 1 cycle.
REQ-034 row_wr and row_rd SHALL never be high simultaneously, and at most one bit of each is high.
REQ-035 Every accepted request SHALL produce exactly one response; no new request is accepted until the response handshake completes.

Reset
REQ-036 rst SHALL force: state IDLE, req_ready=1 the cycle after reset, rsp_valid=0, rsp_err=0, rsp_rdata=0, row_wr=0, row_rd=0, bl_wr=blb_wr=VSS.
REQ-037 rst asserted mid-write or mid-read SHALL drop row lines within the same edge and abort with no response.

Structure
REQ-038 Package sram_pkg SHALL hold VDD=1.5, VSS=0.0, VTH=0.8 and the FSM state enum.
REQ-039 One sub-module, sram_sense_amp (real bl_rd -> 1-bit, threshold VTH), SHALL be instantiated per column.

Verification
REQ-040 Write 4'b1010 to addr 3 -> bl_wr={VDD,VSS,VDD,VSS} for 4 cycles; row_wr=8'b0000_1000 for exactly 2 cycles; rsp_valid 4 cycles after accept; rsp_err=0.
REQ-041 Read addr 3 with cells model connected after REQ-040 -> row_rd[3] high 3 cycles; rsp_rdata=4'b1010 after 3 cycles.
REQ-042 Read with bl_rd={0.79,0.80,1.5,0.0} -> rsp_rdata=4'b0110.
REQ-043 ROWS=6, addr 7 -> rsp_err=1 after 1 cycle; row lines stay 0; rsp_rdata=0.
REQ-044 rsp_ready held low 5 cycles -> rsp_valid and data stable, req_ready=0; release -> IDLE the next cycle.
REQ-045 rst asserted in WR_PULSE cycle 1 -> row_wr=0 and bitlines=VSS the next edge; no rsp_valid.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg
//   Shared definitions for the SRAM read/write controller:
//   - analog rail and sense-threshold voltages used on the bitlines
//   - the controller FSM state encoding
package sram_pkg;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_RD_ACCESS,
    ST_RD_SENSE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/sram_sense_amp.sv
// sram_sense_amp
//   Single-column sense amplifier: resolves an analog read bitline voltage
//   to a logic bit against the VTH threshold (at or above VTH reads as 1).
// Ports
//   bl   : input real   read bitline voltage
//   dout : output logic resolved data bit
module sram_sense_amp
  import sram_pkg::*;
(
  input  real  bl,
  output logic dout
);

  assign dout = (bl >= VTH);

endmodule

// File: rtl/sram_rw_ctrl.sv
// sram_rw_ctrl
//   Request/response controller sequencing word lines and write bitlines of
//   a ROWS x WIDTH SRAM array, and sensing the read bitlines.
//   Writes: IDLE -> WR_SETUP -> WR_PULSE (WR_CYC) -> WR_HOLD -> RESP
//   Reads : IDLE -> RD_ACCESS (RD_CYC) -> RD_SENSE -> RESP
//   Out-of-range addresses go straight to RESP with rsp_err set.
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/req_ready       : request handshake (ready only in IDLE)
//   req_we/req_addr/req_wdata : request command, row address, write data
//   rsp_valid/rsp_ready       : response handshake
//   rsp_rdata/rsp_err         : read data (0 for writes/errors), range error
//   row_wr/row_rd             : one-hot write/read word lines
//   bl_wr/blb_wr              : write bitline pair voltages
//   bl_rd/blb_rd              : read bitline voltages (blb only monitored)
module sram_rw_ctrl
  import sram_pkg::*;
#(
  parameter  int ROWS   = 8,
  parameter  int WIDTH  = 4,
  parameter  int WR_CYC = 2,
  parameter  int RD_CYC = 2,
  localparam int AW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [ROWS-1:0]  row_wr,
  output logic [ROWS-1:0]  row_rd,
  output real              bl_wr  [WIDTH],
  output real              blb_wr [WIDTH],
  input  real              bl_rd  [WIDTH],
  input  real              blb_rd [WIDTH]
);

  localparam int MAX_CYC = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] sense_bits;
  logic [WIDTH-1:0] blb_mon_unused;
  logic             drive_bl;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          // The write/read decision is taken here, so only the address and
          // data need to survive past the accept edge.
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          if (32'(req_addr) >= ROWS) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = req_we ? ST_WR_SETUP : ST_RD_ACCESS;
          end
        end
      end

      ST_WR_SETUP: begin
        cnt_d   = '0;
        state_d = ST_WR_PULSE;
      end

      ST_WR_PULSE: begin
        if (cnt_q == CW'(WR_CYC - 1)) begin
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_WR_HOLD: begin
        state_d = ST_RESP;
      end

      ST_RD_ACCESS: begin
        if (cnt_q == CW'(RD_CYC - 1)) begin
          state_d = ST_RD_SENSE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RD_SENSE: begin
        // Word line is still high on this edge, so the bitlines are valid.
        rdata_d = sense_bits;
        state_d = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;

  // Bitlines are driven for the whole setup/pulse/hold window so data is
  // stable before the word line rises and after it falls.
  assign drive_bl = (state_q == ST_WR_SETUP) || (state_q == ST_WR_PULSE) ||
                    (state_q == ST_WR_HOLD);

  // Word lines decode from registered state/address only, so a reset edge
  // drops them immediately. addr_q is always in range in these states.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign row_wr[gi] = (state_q == ST_WR_PULSE) && (32'(addr_q) == gi);
      assign row_rd[gi] = ((state_q == ST_RD_ACCESS) || (state_q == ST_RD_SENSE)) &&
                          (32'(addr_q) == gi);
    end

    for (gi = 0; gi < WIDTH; gi++) begin : g_col
      sram_sense_amp u_sense_amp (
        .bl   (bl_rd[gi]),
        .dout (sense_bits[gi])
      );
      // The complementary read bitline is observed only; the data decision
      // uses bl_rd alone.
      assign blb_mon_unused[gi] = (blb_rd[gi] >= VTH);
      assign bl_wr[gi]  = drive_bl ? (wdata_q[gi] ? VDD : VSS) : VSS;
      assign blb_wr[gi] = drive_bl ? (wdata_q[gi] ? VSS : VDD) : VSS;
    end
  endgenerate

endmodule
